// File: rtl/inst_mem_loader.sv
// inst_mem_loader: loads a byte stream (count, MSB-first words, XOR checksum) into instruction memory, then releases the CPU
module inst_mem_loader #(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        im_we,
    output logic [31:0] im_addr,
    output logic [31:0] im_wdata,
    output logic        cpu_run,
    output logic        load_err,
    output logic [7:0]  words_loaded
);
    typedef enum logic [2:0] {IDLE, LOAD, WRITE, CHECK, DONE, ERROR} state_t;
    state_t      r_state, w_next;
    logic [7:0]  r_n, r_cnt, r_xor;
    logic [1:0]  r_idx;
    logic [23:0] r_word;
    logic [31:0] r_addr, r_wdata;
    logic        w_acc;
    assign w_acc        = in_valid & in_ready;
    assign in_ready     = !rst && (r_state == IDLE || r_state == LOAD || r_state == CHECK);
    assign im_we        = !rst && r_state == WRITE;
    assign cpu_run      = !rst && r_state == DONE;
    assign load_err     = !rst && r_state == ERROR;
    assign im_addr      = r_addr;
    assign im_wdata     = r_wdata;
    assign words_loaded = r_cnt;
    // State register
    always_ff @(posedge clk) begin
        r_state <= rst ? IDLE : w_next;
    end
    // Next-state: header decode, word completion, write turnaround, checksum verdict
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_acc) w_next = (32'(in_data) > DEPTH) ? ERROR : (in_data == 8'd0 ? CHECK : LOAD);
            LOAD:    if (w_acc && r_idx == 2'd3) w_next = WRITE;
            WRITE:   w_next = (r_cnt + 8'd1 < r_n) ? LOAD : CHECK;
            CHECK:   if (w_acc) w_next = (in_data == r_xor) ? DONE : ERROR;
            default: w_next = r_state;
        endcase
    end
    // Datapath: word assembly, running XOR, write address/data capture, word count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_n     <= '0;
            r_cnt   <= '0;
            r_xor   <= '0;
            r_idx   <= '0;
            r_word  <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            if (r_state == IDLE && w_acc) r_n <= in_data;
            if (r_state == LOAD && w_acc) begin
                r_idx  <= r_idx + 2'd1;
                r_word <= {r_word[15:0], in_data};
                r_xor  <= r_xor ^ in_data;
                if (r_idx == 2'd3) begin
                    r_wdata <= {r_word, in_data};
                    r_addr  <= ADDR_BASE + {22'd0, r_cnt, 2'b00};
                end
            end
            if (r_state == WRITE) r_cnt <= r_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_inst_mem_loader.sv
// tb_inst_mem_loader: randomized scoreboard bench for inst_mem_loader
module tb_inst_mem_loader;
    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready, im_we, cpu_run, load_err;
    logic [31:0] im_addr, im_wdata;
    logic [7:0]  words_loaded;
    int          checks = 0, passes = 0;
    logic [63:0] exp_q[$];
    logic [7:0]  data_q[$];
    logic [63:0] mon_e;

    inst_mem_loader #(.DEPTH(DEPTH), .ADDR_BASE(BASE)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .cpu_run(cpu_run),
        .load_err(load_err), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every write strobe must match the next expected write, one entry per cycle
    always @(negedge clk) begin
        if (im_we !== 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_write: im_we=%b addr %h data %h, expected no write", im_we, im_addr, im_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("im_addr", 64'(im_addr), 64'(mon_e[63:32]));
                check("im_wdata", 64'(im_wdata), 64'(mon_e[31:0]));
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit ok;
        ok = 1'b0;
        if (gaps) repeat ($urandom_range(0, 3)) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            $display("FAIL accept_timeout: byte %h not taken, in_ready=%b expected 1", b, in_ready);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_im_we", 64'(im_we), 64'(0));
        check("rst_cpu_run", 64'(cpu_run), 64'(0));
        check("rst_load_err", 64'(load_err), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_words_loaded", 64'(words_loaded), 64'(0));
        check("rst_im_addr", 64'(im_addr), 64'(0));
        check("rst_im_wdata", 64'(im_wdata), 64'(0));
        check("idle_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
    endtask

    function automatic logic [7:0] xsum();
        logic [7:0] x = 8'd0;
        foreach (data_q[i]) x ^= data_q[i];
        return x;
    endfunction

    task automatic fill(input int n);
        data_q.delete();
        repeat (4 * n) data_q.push_back(8'($urandom));
    endtask

    // Reference: header, then 4*n bytes of data_q as MSB-first words at BASE+4*i, then checksum
    task automatic run_stream(input int n, input logic [7:0] chk, input bit gaps);
        bit       exp_run, exp_err;
        int       exp_wl;
        if (n > DEPTH) begin
            exp_run = 1'b0; exp_err = 1'b1; exp_wl = 0;
            send_byte(8'(n), gaps);
        end else begin
            for (int i = 0; i < n; i++)
                exp_q.push_back({BASE + 32'(4 * i), data_q[4*i], data_q[4*i+1], data_q[4*i+2], data_q[4*i+3]});
            exp_run = (chk == xsum());
            exp_err = !exp_run;
            exp_wl  = n;
            send_byte(8'(n), gaps);
            foreach (data_q[i]) send_byte(data_q[i], gaps);
            send_byte(chk, gaps);
        end
        repeat (3) @(negedge clk);
        check("cpu_run", 64'(cpu_run), 64'(exp_run));
        check("load_err", 64'(load_err), 64'(exp_err));
        check("words_loaded", 64'(words_loaded), 64'(exp_wl));
        check("final_in_ready", 64'(in_ready), 64'(0));
        check("pending_writes", 64'(exp_q.size()), 64'(0));
        in_valid = 1'b1;
        repeat (4) begin
            in_data = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("hold_cpu_run", 64'(cpu_run), 64'(exp_run));
        check("hold_words_loaded", 64'(words_loaded), 64'(exp_wl));
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] c;
        int         n;
        do_reset();
        data_q = '{8'h8C, 8'h01, 8'h00, 8'h00, 8'h00, 8'h22, 8'h18, 8'h20};
        run_stream(2, xsum(), 1'b0);
        do_reset();
        data_q.delete();
        run_stream(0, 8'h00, 1'b0);
        do_reset();
        run_stream(0, 8'h5A, 1'b0);
        do_reset();
        run_stream(DEPTH + 1, 8'h00, 1'b0);
        do_reset();
        data_q = '{8'h00, 8'h00, 8'h00, 8'h20};
        run_stream(1, 8'h21, 1'b0);
        do_reset();
        fill(3);
        run_stream(3, xsum(), 1'b1);
        do_reset();
        fill(DEPTH);
        run_stream(DEPTH, xsum(), 1'b0);
        do_reset();
        send_byte(8'd2, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        do_reset();
        fill(2);
        run_stream(2, xsum(), 1'b1);
        do_reset();
        send_byte(8'd1, 1'b0);
        repeat (4) send_byte(8'($urandom), 1'b0);
        do_reset();
        fill(1);
        run_stream(1, xsum(), 1'b0);
        do_reset();
        repeat (10) begin
            n = $urandom_range(0, 6);
            fill(n);
            c = xsum();
            if ($urandom_range(0, 3) == 0) c ^= 8'(1 << $urandom_range(0, 7));
            run_stream(n, c, 1'b1);
            do_reset();
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
